// File: rtl/ysyx_25030077_pkg.sv
// Shared encodings for the program-counter unit: next-PC control types,
// FSM states and trap cause codes.
package ysyx_25030077_pkg;

  localparam logic [3:0] PC_SEQ    = 4'd0;
  localparam logic [3:0] PC_JAL    = 4'd1;
  localparam logic [3:0] PC_JALR   = 4'd2;
  localparam logic [3:0] PC_EBREAK = 4'd4;
  localparam logic [3:0] PC_BNE    = 4'd5;
  localparam logic [3:0] PC_BEQ    = 4'd6;
  localparam logic [3:0] PC_BGE    = 4'd7;
  localparam logic [3:0] PC_BGEU   = 4'd8;
  localparam logic [3:0] PC_BLT    = 4'd9;
  localparam logic [3:0] PC_BLTU   = 4'd10;
  localparam logic [3:0] PC_ECALL  = 4'd11;
  localparam logic [3:0] PC_MRET   = 4'd12;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;

endpackage

// File: rtl/ysyx_25030077_branch_cmp.sv
// Combinational branch comparator and immediate-target adders for the PC unit.
module ysyx_25030077_branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [31:0]     instruction,
  output logic            eq,
  output logic            ne,
  output logic            lt,
  output logic            ge,
  output logic            ltu,
  output logic            geu,
  output logic [XLEN-1:0] j_target,
  output logic [XLEN-1:0] b_target,
  output logic [XLEN-1:0] i_target
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic            unused_opcode;

  assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  assign eq  = (rs1_data == rs2_data);
  assign lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu = (rs1_data < rs2_data);
  assign ne  = ~eq;
  assign ge  = ~lt;
  assign geu = ~ltu;

  assign j_target = pc + imm_j;
  assign b_target = pc + imm_b;
  assign i_target = (rs1_data + imm_i) & ~XLEN'(1);

  // opcode field is decoded upstream; only immediate bits matter here
  assign unused_opcode = ^instruction[6:0];

endmodule

// File: rtl/ysyx_25030077_pc_unit.sv
// PC register, fetch/exec handshake FSM, trap registers and retire counter.
// States: ST_FETCH | fetch request out; ST_EXEC | waiting for next-PC control; ST_HALT | ebreak seen, frozen
module ysyx_25030077_pc_unit
  import ysyx_25030077_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter bit              C_EXT    = 1'b0,
  parameter int              CNT_W    = 64
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_fetch_valid,
  input  logic             io_fetch_ready,
  input  logic             io_exec_valid,
  output logic             io_exec_ready,
  input  logic [3:0]       io_pc_next_type,
  input  logic [31:0]      io_instruction,
  input  logic [XLEN-1:0]  io_rs1_data,
  input  logic [XLEN-1:0]  io_rs2_data,
  input  logic [XLEN-1:0]  io_mtvec,
  input  logic [XLEN-1:0]  io_mepc,
  output logic [XLEN-1:0]  io_pc,
  output logic             io_trap_valid,
  output logic [3:0]       io_trap_cause,
  output logic [XLEN-1:0]  io_trap_epc,
  output logic             io_halt,
  output logic [CNT_W-1:0] io_retired
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              trap_valid_q, trap_valid_d;
  logic [3:0]        trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              eq, ne, lt, ge, ltu, geu;
  logic [XLEN-1:0]   j_target, b_target, i_target;
  logic [XLEN-1:0]   target;
  logic              chk_align, trap, taken;
  logic [3:0]        cause;

  ysyx_25030077_branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .pc          (pc_q),
    .rs1_data    (io_rs1_data),
    .rs2_data    (io_rs2_data),
    .instruction (io_instruction),
    .eq          (eq),
    .ne          (ne),
    .lt          (lt),
    .ge          (ge),
    .ltu         (ltu),
    .geu         (geu),
    .j_target    (j_target),
    .b_target    (b_target),
    .i_target    (i_target)
  );

  always_comb begin
    target    = pc_q + XLEN'(4);
    chk_align = 1'b0;
    trap      = 1'b0;
    taken     = 1'b0;
    cause     = CAUSE_ILLEGAL;
    case (io_pc_next_type)
      PC_SEQ:    target = pc_q + XLEN'(4);
      PC_JAL:    begin target = j_target; chk_align = 1'b1; end
      PC_JALR:   begin target = i_target; chk_align = 1'b1; end
      PC_EBREAK: target = pc_q;
      PC_BNE:    taken = ne;
      PC_BEQ:    taken = eq;
      PC_BGE:    taken = ge;
      PC_BGEU:   taken = geu;
      PC_BLT:    taken = lt;
      PC_BLTU:   taken = ltu;
      PC_ECALL:  begin trap = 1'b1; cause = CAUSE_ECALL_M; end
      PC_MRET:   target = io_mepc;
      default:   begin trap = 1'b1; cause = CAUSE_ILLEGAL; end
    endcase
    if (taken) begin
      target    = b_target;
      chk_align = 1'b1;
    end
    // with 2-byte instructions every even target is legal
    if (chk_align && !C_EXT && target[1]) begin
      trap  = 1'b1;
      cause = CAUSE_MISALIGN;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_valid_d = 1'b0;
    trap_cause_d = trap_cause_q;
    trap_epc_d   = trap_epc_q;
    halt_d       = halt_q;
    retired_d    = retired_q;
    case (state_q)
      ST_FETCH: if (io_fetch_ready) state_d = ST_EXEC;
      ST_EXEC: begin
        if (io_exec_valid) begin
          state_d = ST_FETCH;
          if (trap) begin
            pc_d         = io_mtvec & ~XLEN'(3);
            trap_valid_d = 1'b1;
            trap_cause_d = cause;
            trap_epc_d   = pc_q;
          end else begin
            pc_d      = target;
            retired_d = retired_q + CNT_W'(1);
            if (io_pc_next_type == PC_EBREAK) begin
              state_d = ST_HALT;
              halt_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      trap_valid_q <= 1'b0;
      trap_cause_q <= 4'd0;
      trap_epc_q   <= '0;
      halt_q       <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_valid_q <= trap_valid_d;
      trap_cause_q <= trap_cause_d;
      trap_epc_q   <= trap_epc_d;
      halt_q       <= halt_d;
      retired_q    <= retired_d;
    end
  end

  assign io_fetch_valid = (state_q == ST_FETCH);
  assign io_exec_ready  = (state_q == ST_EXEC);
  assign io_pc          = pc_q;
  assign io_trap_valid  = trap_valid_q;
  assign io_trap_cause  = trap_cause_q;
  assign io_trap_epc    = trap_epc_q;
  assign io_halt        = halt_q;
  assign io_retired     = retired_q;

endmodule

// File: tb/tb_ysyx_25030077_pc_unit.sv
// Scoreboard bench for the PC unit: expected post-instruction state is queued
// when an instruction is driven and compared once the unit has consumed it.
module tb_ysyx_25030077_pc_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_fetch_valid;
  logic        io_fetch_ready = 1'b0;
  logic        io_exec_valid = 1'b0;
  logic        io_exec_ready;
  logic [3:0]  io_pc_next_type = 4'd0;
  logic [31:0] io_instruction = 32'd0;
  logic [31:0] io_rs1_data = 32'd0;
  logic [31:0] io_rs2_data = 32'd0;
  logic [31:0] io_mtvec = 32'h8000_1003;
  logic [31:0] io_mepc = 32'h8000_0020;
  logic [31:0] io_pc;
  logic        io_trap_valid;
  logic [3:0]  io_trap_cause;
  logic [31:0] io_trap_epc;
  logic        io_halt;
  logic [63:0] io_retired;

  ysyx_25030077_pc_unit dut (
    .clock           (clock),
    .reset           (reset),
    .io_fetch_valid  (io_fetch_valid),
    .io_fetch_ready  (io_fetch_ready),
    .io_exec_valid   (io_exec_valid),
    .io_exec_ready   (io_exec_ready),
    .io_pc_next_type (io_pc_next_type),
    .io_instruction  (io_instruction),
    .io_rs1_data     (io_rs1_data),
    .io_rs2_data     (io_rs2_data),
    .io_mtvec        (io_mtvec),
    .io_mepc         (io_mepc),
    .io_pc           (io_pc),
    .io_trap_valid   (io_trap_valid),
    .io_trap_cause   (io_trap_cause),
    .io_trap_epc     (io_trap_epc),
    .io_halt         (io_halt),
    .io_retired      (io_retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic        tv;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [63:0] ret;
  } obs_t;

  typedef struct packed {
    logic [3:0]  t;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    obs_t        e;
  } stim_t;

  obs_t sb[$];
  obs_t obs;
  obs_t exp_v;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] enc_i(input logic [31:0] imm);
    return {imm[11:0], 20'd0};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
  endfunction

  // One full fetch+exec handshake; obs goes to X if the unit never handshakes.
  task automatic run_instr(input logic [3:0] t, input logic [31:0] inst,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    int  n;
    bit  to;
    to = 1'b0;
    n  = 0;
    while (!io_fetch_valid && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) to = 1'b1;
    io_fetch_ready = 1'b1;
    @(negedge clock);
    io_fetch_ready = 1'b0;
    n = 0;
    while (!io_exec_ready && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) to = 1'b1;
    io_pc_next_type = t;
    io_instruction  = inst;
    io_rs1_data     = rs1;
    io_rs2_data     = rs2;
    io_exec_valid   = 1'b1;
    @(negedge clock);
    io_exec_valid = 1'b0;
    if (to) obs = 'x;
    else    obs = {io_pc, io_trap_valid, io_trap_cause, io_trap_epc, io_retired};
  endtask

  task automatic test_reset();
    n_tests++;
    if ({io_pc, io_fetch_valid, io_exec_ready, io_trap_valid, io_trap_cause,
         io_trap_epc, io_halt, io_retired} !==
        {32'h8000_0000, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset: pc=%h fv=%b er=%b tv=%b cause=%0d epc=%h halt=%b ret=%0d expected pc=80000000 fv=1 er=0 rest 0",
               io_pc, io_fetch_valid, io_exec_ready, io_trap_valid, io_trap_cause,
               io_trap_epc, io_halt, io_retired);
    end
  endtask

  task automatic test_seq();
    stim_t tbl[4];
    tbl[0] = {4'd0, 32'd0, 32'd0, 32'd0, {32'h8000_0004, 1'b0, 4'd0, 32'd0, 64'd1}};
    tbl[1] = {4'd0, 32'd0, 32'd0, 32'd0, {32'h8000_0008, 1'b0, 4'd0, 32'd0, 64'd2}};
    tbl[2] = {4'd0, 32'd0, 32'd0, 32'd0, {32'h8000_000c, 1'b0, 4'd0, 32'd0, 64'd3}};
    tbl[3] = {4'd0, 32'd0, 32'd0, 32'd0, {32'h8000_0010, 1'b0, 4'd0, 32'd0, 64'd4}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(tbl[i].e);
      run_instr(tbl[i].t, tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      exp_v = sb.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
                 i, obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
                 exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
      end
    end
  endtask

  task automatic test_branch();
    stim_t tbl[9];
    logic [31:0] m8, p8;
    m8 = 32'hFFFF_FFF8;
    p8 = 32'd8;
    tbl[0] = {4'd6,  enc_b(m8), 32'd5, 32'd5, {32'h8000_0008, 1'b0, 4'd0, 32'd0, 64'd5}};
    tbl[1] = {4'd0,  32'd0,     32'd0, 32'd0, {32'h8000_000c, 1'b0, 4'd0, 32'd0, 64'd6}};
    tbl[2] = {4'd0,  32'd0,     32'd0, 32'd0, {32'h8000_0010, 1'b0, 4'd0, 32'd0, 64'd7}};
    tbl[3] = {4'd6,  enc_b(m8), 32'd5, 32'd6, {32'h8000_0014, 1'b0, 4'd0, 32'd0, 64'd8}};
    tbl[4] = {4'd9,  enc_b(p8), 32'hFFFF_FFFF, 32'd1, {32'h8000_001c, 1'b0, 4'd0, 32'd0, 64'd9}};
    tbl[5] = {4'd10, enc_b(p8), 32'hFFFF_FFFF, 32'd1, {32'h8000_0020, 1'b0, 4'd0, 32'd0, 64'd10}};
    tbl[6] = {4'd5,  enc_b(p8), 32'd5, 32'd6, {32'h8000_0028, 1'b0, 4'd0, 32'd0, 64'd11}};
    tbl[7] = {4'd8,  enc_b(m8), 32'hFFFF_FFFF, 32'd1, {32'h8000_0020, 1'b0, 4'd0, 32'd0, 64'd12}};
    tbl[8] = {4'd7,  enc_b(m8), 32'hFFFF_FFFF, 32'd1, {32'h8000_0024, 1'b0, 4'd0, 32'd0, 64'd13}};
    for (int i = 0; i < 9; i++) begin
      sb.push_back(tbl[i].e);
      run_instr(tbl[i].t, tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      exp_v = sb.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d]: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
                 i, obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
                 exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
      end
    end
  endtask

  task automatic test_jump_misalign();
    stim_t tbl[4];
    io_mtvec = 32'h8000_1003;
    tbl[0] = {4'd2, enc_i(32'd0), 32'h8000_0101, 32'd0, {32'h8000_0100, 1'b0, 4'd0, 32'd0, 64'd14}};
    tbl[1] = {4'd2, enc_i(32'd2), 32'h8000_0101, 32'd0, {32'h8000_1000, 1'b1, 4'd0, 32'h8000_0100, 64'd14}};
    tbl[2] = {4'd1, enc_j(32'd8), 32'd0, 32'd0, {32'h8000_1008, 1'b0, 4'd0, 32'h8000_0100, 64'd15}};
    tbl[3] = {4'd1, enc_j(32'd6), 32'd0, 32'd0, {32'h8000_1000, 1'b1, 4'd0, 32'h8000_1008, 64'd15}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(tbl[i].e);
      run_instr(tbl[i].t, tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      exp_v = sb.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL jump[%0d]: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
                 i, obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
                 exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
      end
    end
  endtask

  task automatic test_ecall_mret();
    io_mtvec = 32'h8000_1003;
    io_mepc  = 32'h8000_0020;
    sb.push_back({32'h8000_1000, 1'b1, 4'd11, 32'h8000_1000, 64'd15});
    run_instr(4'd11, 32'd0, 32'd0, 32'd0);
    exp_v = sb.pop_front();
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL ecall: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
               obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
               exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
    end
    @(negedge clock);
    n_tests++;
    if ({io_trap_valid, io_trap_cause} !== {1'b0, 4'd11}) begin
      n_fail++;
      $display("FAIL ecall_pulse: got tv=%b cause=%0d, want tv=0 cause=11", io_trap_valid, io_trap_cause);
    end
    sb.push_back({32'h8000_0020, 1'b0, 4'd11, 32'h8000_1000, 64'd16});
    run_instr(4'd12, 32'd0, 32'd0, 32'd0);
    exp_v = sb.pop_front();
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL mret: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
               obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
               exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
    end
  endtask

  task automatic test_back_to_back();
    stim_t tbl[2];
    io_mtvec = 32'h8000_1000;
    tbl[0] = {4'd3,  32'd0, 32'd0, 32'd0, {32'h8000_1000, 1'b1, 4'd2, 32'h8000_0020, 64'd16}};
    tbl[1] = {4'd15, 32'd0, 32'd0, 32'd0, {32'h8000_1000, 1'b1, 4'd2, 32'h8000_1000, 64'd16}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(tbl[i].e);
      run_instr(tbl[i].t, tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
      exp_v = sb.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_trap[%0d]: got pc=%h tv=%b cause=%0d epc=%h ret=%0d, want pc=%h tv=%b cause=%0d epc=%h ret=%0d",
                 i, obs.pc, obs.tv, obs.cause, obs.epc, obs.ret,
                 exp_v.pc, exp_v.tv, exp_v.cause, exp_v.epc, exp_v.ret);
      end
    end
  endtask

  task automatic test_ebreak();
    sb.push_back({32'h8000_1000, 1'b0, 4'd2, 32'h8000_1000, 64'd17});
    run_instr(4'd4, 32'd0, 32'd0, 32'd0);
    exp_v = sb.pop_front();
    n_tests++;
    if (obs !== exp_v || {io_halt, io_fetch_valid, io_exec_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL ebreak: got pc=%h ret=%0d halt=%b fv=%b er=%b, want pc=%h ret=%0d halt=1 fv=0 er=0",
               obs.pc, obs.ret, io_halt, io_fetch_valid, io_exec_ready, exp_v.pc, exp_v.ret);
    end
    io_fetch_ready  = 1'b1;
    io_exec_valid   = 1'b1;
    io_pc_next_type = 4'd0;
    repeat (6) @(negedge clock);
    io_fetch_ready = 1'b0;
    io_exec_valid  = 1'b0;
    n_tests++;
    if ({io_pc, io_retired, io_halt, io_fetch_valid, io_exec_ready} !==
        {32'h8000_1000, 64'd17, 3'b100}) begin
      n_fail++;
      $display("FAIL halt_frozen: got pc=%h ret=%0d halt=%b fv=%b er=%b, want pc=80001000 ret=17 halt=1 fv=0 er=0",
               io_pc, io_retired, io_halt, io_fetch_valid, io_exec_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    io_fetch_ready = 1'b1;
    @(negedge clock);
    io_fetch_ready = 1'b0;
    n_tests++;
    if ({io_exec_ready, io_halt, io_retired} !== {1'b1, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got er=%b halt=%b ret=%0d, want er=1 halt=0 ret=0",
               io_exec_ready, io_halt, io_retired);
    end
    sb.push_back({32'h8000_0004, 1'b0, 4'd0, 32'd0, 64'd1});
    io_pc_next_type = 4'd0;
    io_exec_valid   = 1'b1;
    @(negedge clock);
    io_exec_valid = 1'b0;
    obs = {io_pc, io_trap_valid, io_trap_cause, io_trap_epc, io_retired};
    exp_v = sb.pop_front();
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL post_reset_seq: got pc=%h ret=%0d, want pc=%h ret=%0d", obs.pc, obs.ret, exp_v.pc, exp_v.ret);
    end
    // Put the unit into EXEC with a trap pending, then reset between edges
    io_mtvec = 32'h8000_1003;
    io_fetch_ready = 1'b1;
    @(negedge clock);
    io_fetch_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({io_pc, io_fetch_valid, io_exec_ready, io_trap_valid, io_trap_cause,
         io_trap_epc, io_halt, io_retired} !==
        {32'h8000_0000, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_exec: pc=%h fv=%b er=%b tv=%b cause=%0d epc=%h halt=%b ret=%0d expected pc=80000000 fv=1 er=0 rest 0",
               io_pc, io_fetch_valid, io_exec_ready, io_trap_valid, io_trap_cause,
               io_trap_epc, io_halt, io_retired);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    test_seq();
    test_branch();
    test_jump_misalign();
    test_ecall_mret();
    test_back_to_back();
    test_ebreak();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_pc_unit.md
# ysyx_25030077_pc_unit

Sequential program-counter unit for the multi-cycle core. It owns the PC register, issues fetch requests to the IFU, and accepts next-PC control from the EXU through valid/ready handshakes. It resolves jumps, branches, ecall, mret, illegal instructions and misaligned targets in hardware through CSR inputs, with no simulator calls. It is parametrised in XLEN, reset vector, alignment mode and retire-counter width.

## Interface
- XLEN, 32, data/PC width
- RESET_PC, 32'h8000_0000, PC value after reset
- C_EXT, 0, 1 = 2-byte instruction alignment, 0 = 4-byte alignment
- CNT_W, 64, width of the retired-instruction counter
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- io_fetch_valid  out  1  fetch request for io_pc
- io_fetch_ready  in  1  IFU accepts the request
- io_exec_valid  in  1  EXU presents next-PC control
- io_exec_ready  out  1  unit accepts the control
- io_pc_next_type  in  4  0 seq, 1 jal, 2 jalr, 3 unknown, 4 ebreak, 5 bne, 6 beq, 7 bge, 8 bgeu, 9 blt, 10 bltu, 11 ecall, 12 mret, 13–15 unknown
- io_instruction  in  32  current instruction, used for immediates
- io_rs1_data, io_rs2_data  in  XLEN  operands
- io_mtvec, io_mepc  in  XLEN  CSR values
- io_pc  out  XLEN  current PC register
- io_trap_valid  out  1  one-cycle trap pulse
- io_trap_cause  out  4  0 misaligned fetch, 2 illegal, 11 ecall-M
- io_trap_epc  out  XLEN  PC of the trapping instruction
- io_halt  out  1  ebreak reached
- io_retired  out  CNT_W  count of retired instructions

## Operation
- Three states:
  - FETCH: io_fetch_valid = 1.
  - EXEC: io_exec_ready = 1.
  - HALT: both handshake outputs are 0.
- FETCH → EXEC on io_fetch_valid && io_fetch_ready.
- EXEC → FETCH on io_exec_valid && io_exec_ready. The PC is updated in the same edge.
- EXEC → HALT on handshake with type 4. The PC holds and io_halt latches 1 until reset.
- Next-PC rules, with seq = pc + 4:
  - Types 0 and 13–15 and 3: type 0 gives seq. Types 3 and 13–15 are illegal: trap with cause 2, next = mtvec & ~3.
  - jal: pc + sext J-immediate.
  - jalr: (rs1 + sext I-immediate) & ~1.
  - Branches (types 5–10): pc + sext B-immediate if the condition holds, else seq. bge and blt are signed; bgeu and bltu are unsigned.
  - ecall: trap with cause 11, next = mtvec & ~3.
  - mret: next = mepc.
- Misalignment: a taken jal, jalr or branch target with bit1 set when C_EXT = 0 does not update to that target. It traps with cause 0 and next = mtvec & ~3. When C_EXT = 1, no misalignment is possible.
- Trap side effects: io_trap_epc = pc of the faulting instruction. io_trap_valid pulses for exactly one cycle.
- Arithmetic: all adds are XLEN-bit and wrap modulo 2^XLEN with no overflow detection. Immediates are sign-extended to XLEN.
- Retire counter: io_retired increments by 1 on every EXEC handshake except trapping ones. Ebreak counts as retired. The counter wraps at 2^CNT_W.
- Inputs outside their state are ignored: io_fetch_ready outside FETCH, io_exec_valid outside EXEC.

## Timing
- Reset values while reset = 0:
  - state FETCH, io_pc = RESET_PC.
  - io_fetch_valid = 1, io_exec_ready = 0.
  - io_trap_valid = 0, io_trap_cause = 0, io_trap_epc = 0.
  - io_halt = 0, io_retired = 0.
- Reset asserted mid-operation returns to these values immediately, asynchronously.
- io_fetch_valid and io_exec_ready are decoded from registered state, with no combinational path from inputs.
- io_pc changes only on the edge of an EXEC handshake. It is stable through FETCH and EXEC.
- io_trap_valid, io_trap_cause and io_trap_epc are registered. They appear the cycle after the trapping handshake, coincident with the new io_pc. The cause and epc hold until the next trap.
- Minimum loop: 2 cycles per instruction (FETCH 1 cycle, EXEC 1 cycle) with both ready/valid tied high.
- Back-to-back trap (the mtvec target itself illegal) produces a new pulse each iteration with no suppression.

## Structure
- Package ysyx_25030077_pkg holds:
  - the pc_next_type encodings
  - the state enum (FETCH/EXEC/HALT)
  - the trap cause constants (CAUSE_MISALIGN = 0, CAUSE_ILLEGAL = 2, CAUSE_ECALL_M = 11)
- Sub-module ysyx_25030077_branch_cmp is combinational. It produces the six comparison flags and the three immediate targets (J, B, I), parametrised by XLEN.
- The top level holds the FSM, PC register, trap registers and retire counter.

## Test plan
- Reset, then fetch_ready = 1 and type 0 → io_pc sequence 0x80000000, 0x80000004, 0x80000008; io_retired = 2.
- beq with rs1 = rs2 = 5 and imm −8 at pc 0x80000010 → 0x80000008. With rs1 = 5, rs2 = 6 → 0x80000014.
- blt with rs1 = 0xFFFFFFFF, rs2 = 1 → taken. bltu with the same operands → not taken.
- jalr with rs1 = 0x80000101 and imm 0, C_EXT = 0 → target 0x80000100 accepted. With imm 2 → trap cause 0, epc = pc, io_pc = mtvec & ~3, retired unchanged.
- ecall with mtvec = 0x80001003 → io_pc 0x80001000 and trap_valid for one cycle, cause 11. Then mret with mepc = 0x80000020 → io_pc 0x80000020.
- ebreak → io_halt = 1, both handshakes 0, io_pc frozen. Reset asserted mid-EXEC → all reset values immediately.
